// File: rtl/riscv_lsu_split.sv
// riscv_lsu_split: load/store unit that splits misaligned accesses into two word beats
// with per-beat timeout, byte-lane steering and load sign/zero extension.
module riscv_lsu_split #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter bit          MISALIGN_EN    = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);
    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;
    localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;

    logic          beat_q;
    logic [31:0]   lo_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    off;
    logic [2:0]    nbytes;
    logic          size_ok, split, legal, last, fin, timeout;
    logic [7:0]    be8;
    logic [63:0]   lane64, wd64, r64;
    logic [31:0]   field;

    always_comb begin
        off     = core_addr_i[1:0];
        size_ok = core_size_i inside {LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU};
        nbytes  = core_size_i == LDST_W ? 3'd4 :
                  (core_size_i == LDST_H || core_size_i == LDST_HU) ? 3'd2 : 3'd1;
        split   = ({1'b0, off} + nbytes) > 3'd4;
        legal   = size_ok && (MISALIGN_EN || !split);
        be8     = (nbytes == 3'd4 ? 8'h0F : nbytes == 3'd2 ? 8'h03 : 8'h01) << off;
        lane64  = '0;
        for (int i = 0; i < 8; i++) lane64[8*i +: 8] = {8{be8[i]}};
        wd64    = ({32'b0, core_wd_i} << {off, 3'b000}) & lane64;
        r64     = split ? {mem_rd_i, lo_q} : {32'b0, mem_rd_i};
        field   = 32'(r64 >> {off, 3'b000});
    end

    assign mem_req_o    = core_req_i && legal;
    assign last         = !split || beat_q;
    assign fin          = mem_req_o && last && mem_ready_i;
    assign timeout      = (TIMEOUT_CYCLES != 0) && mem_req_o && !mem_ready_i &&
                          cnt_q == CW'(TIMEOUT_CYCLES - 1);
    assign mem_we_o     = mem_req_o && core_we_i;
    assign mem_be_o     = mem_req_o ? (beat_q ? be8[7:4] : be8[3:0]) : 4'b0;
    assign mem_addr_o   = mem_req_o ? {core_addr_i[31:2], 2'b00} + {29'b0, beat_q, 2'b00} : 32'b0;
    assign mem_wd_o     = mem_we_o ? (beat_q ? wd64[63:32] : wd64[31:0]) : 32'b0;
    assign core_stall_o = mem_req_o && !fin && !timeout;
    assign core_err_o   = (core_req_i && !legal) || timeout;
    assign core_rd_o    = (!fin || core_we_i) ? 32'b0 :
                          core_size_i == LDST_W  ? field :
                          core_size_i == LDST_B  ? {{24{field[7]}}, field[7:0]} :
                          core_size_i == LDST_H  ? {{16{field[15]}}, field[15:0]} :
                          core_size_i == LDST_BU ? {24'b0, field[7:0]} :
                                                   {16'b0, field[15:0]};

    // Beat-0 completion of a split access is the only ready that is not a fin.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_q <= 1'b0;
            lo_q   <= '0;
            cnt_q  <= '0;
        end else if (!core_req_i || timeout || fin) begin
            beat_q <= 1'b0;
            cnt_q  <= '0;
        end else if (mem_req_o && mem_ready_i) begin
            lo_q   <= mem_rd_i;
            beat_q <= 1'b1;
            cnt_q  <= '0;
        end else if (mem_req_o) begin
            cnt_q  <= cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_riscv_lsu_split.sv
// tb_riscv_lsu_split: scoreboard bench; stimulus queues expected outputs, a negedge monitor compares.
module tb_riscv_lsu_split;
    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

    logic        clk = 1'b0, rst_ni = 1'b0;
    logic        req = 1'b0, req2 = 1'b0, we = 1'b0, rdy = 1'b0;
    logic [2:0]  sz = 3'b0;
    logic [31:0] addr = '0, wd = '0, rd = '0;
    logic [31:0] rd_o1, addr_o1, wd_o1, rd_o2, addr_o2, wd_o2;
    logic        st1, er1, mr1, mw1, st2, er2, mr2, mw2;
    logic [3:0]  be1, be2;
    logic [103:0] q1[$], q2[$];
    int errors = 0, checks = 0;
    bit done = 1'b0, drained = 1'b0;

    always #5 clk = ~clk;

    riscv_lsu_split #(.TIMEOUT_CYCLES(4), .MISALIGN_EN(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .core_req_i(req), .core_we_i(we), .core_size_i(sz),
        .core_addr_i(addr), .core_wd_i(wd), .core_rd_o(rd_o1), .core_stall_o(st1),
        .core_err_o(er1), .mem_req_o(mr1), .mem_we_o(mw1), .mem_be_o(be1),
        .mem_addr_o(addr_o1), .mem_wd_o(wd_o1), .mem_rd_i(rd), .mem_ready_i(rdy)
    );

    riscv_lsu_split #(.TIMEOUT_CYCLES(16), .MISALIGN_EN(1'b0)) dut2 (
        .clk_i(clk), .rst_ni(rst_ni), .core_req_i(req2), .core_we_i(we), .core_size_i(sz),
        .core_addr_i(addr), .core_wd_i(wd), .core_rd_o(rd_o2), .core_stall_o(st2),
        .core_err_o(er2), .mem_req_o(mr2), .mem_we_o(mw2), .mem_be_o(be2),
        .mem_addr_o(addr_o2), .mem_wd_o(wd_o2), .mem_rd_i(rd), .mem_ready_i(rdy)
    );

    function automatic logic [103:0] pk(input logic r, w, input logic [3:0] b, input logic [31:0] a, d,
                                        input logic s, e, input logic [31:0] o);
        return {r, w, b, a, d, s, e, o};
    endfunction

    task automatic cmp(input string name, input logic [103:0] act, input logic [103:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [103:0] a1, a2, e1, e2;
        a1 = {mr1, mw1, be1, addr_o1, wd_o1, st1, er1, rd_o1};
        a2 = {mr2, mw2, be2, addr_o2, wd_o2, st2, er2, rd_o2};
        e1 = '0;
        e2 = '0;
        if ((mr1 | er1) === 1'b1 && q1.size() > 0) e1 = q1.pop_front();
        if ((mr2 | er2) === 1'b1 && q2.size() > 0) e2 = q2.pop_front();
        cmp("dut_outputs", a1, e1);
        cmp("dut2_outputs", a2, e2);
        if (done && !drained) begin
            cmp("dut_queue_left", 104'(q1.size()), '0);
            cmp("dut2_queue_left", 104'(q2.size()), '0);
            drained = 1'b1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set(input logic r, w, input logic [2:0] s, input logic [31:0] a, d, m, input logic y);
        req = r; req2 = 1'b0; we = w; sz = s; addr = a; wd = d; rd = m; rdy = y;
    endtask

    task automatic set2(input logic r, w, input logic [2:0] s, input logic [31:0] a, d, m, input logic y);
        set(1'b0, w, s, a, d, m, y);
        req2 = r;
    endtask

    task automatic ex(input logic r, w, input logic [3:0] b, input logic [31:0] a, d,
                      input logic s, e, input logic [31:0] o);
        q1.push_back(pk(r, w, b, a, d, s, e, o));
    endtask

    task automatic ex2(input logic r, w, input logic [3:0] b, input logic [31:0] a, d,
                       input logic s, e, input logic [31:0] o);
        q2.push_back(pk(r, w, b, a, d, s, e, o));
    endtask

    initial begin
        repeat (2) tick;
        rst_ni = 1'b1;
        tick;
        // split LW across words
        set(1, 0, W, 32'h1002, 0, 32'hDDCCBBAA, 1); ex(1, 0, 4'hC, 32'h1000, 0, 1, 0, 0); tick;
        set(1, 0, W, 32'h1002, 0, 32'h44332211, 1); ex(1, 0, 4'h3, 32'h1004, 0, 0, 0, 32'h2211DDCC); tick;
        set(0, 0, B, 0, 0, 0, 0); tick;
        // split SW, then back-to-back aligned accesses
        set(1, 1, W, 32'h103, 32'hA1B2C3D4, 0, 1); ex(1, 1, 4'h8, 32'h100, 32'hD4000000, 1, 0, 0); tick;
        set(1, 1, W, 32'h103, 32'hA1B2C3D4, 0, 1); ex(1, 1, 4'h7, 32'h104, 32'h00A1B2C3, 0, 0, 0); tick;
        set(1, 0, B, 32'h3, 0, 32'h80000000, 1); ex(1, 0, 4'h8, 0, 0, 0, 0, 32'hFFFFFF80); tick;
        set(1, 0, HU, 32'h2, 0, 32'hBEEF1234, 1); ex(1, 0, 4'hC, 0, 0, 0, 0, 32'h0000BEEF); tick;
        set(1, 1, B, 32'h1, 32'h12345678, 0, 1); ex(1, 1, 4'h2, 0, 32'h00007800, 0, 0, 0); tick;
        set(1, 1, H, 32'h2, 32'hAABBCCDD, 0, 1); ex(1, 1, 4'hC, 0, 32'hCCDD0000, 0, 0, 0); tick;
        set(1, 0, H, 32'h1, 0, 32'h00F0FF00, 1); ex(1, 0, 4'h6, 0, 0, 0, 0, 32'hFFFFF0FF); tick;
        set(1, 0, BU, 32'h2, 0, 32'h00AB0000, 1); ex(1, 0, 4'h4, 0, 0, 0, 0, 32'h000000AB); tick;
        // split LH at offset 3
        set(1, 0, H, 32'h3, 0, 32'h11000000, 1); ex(1, 0, 4'h8, 0, 0, 1, 0, 0); tick;
        set(1, 0, H, 32'h3, 0, 32'h000000FF, 1); ex(1, 0, 4'h1, 32'h4, 0, 0, 0, 32'hFFFFFF11); tick;
        // one wait state
        set(1, 0, W, 32'h20, 0, 32'hCAFEF00D, 0); ex(1, 0, 4'hF, 32'h20, 0, 1, 0, 0); tick;
        set(1, 0, W, 32'h20, 0, 32'hCAFEF00D, 1); ex(1, 0, 4'hF, 32'h20, 0, 0, 0, 32'hCAFEF00D); tick;
        // aligned timeout, then held request restarts
        for (int i = 0; i < 3; i++) begin
            set(1, 0, W, 32'h40, 0, 32'h5555AAAA, 0); ex(1, 0, 4'hF, 32'h40, 0, 1, 0, 0); tick;
        end
        set(1, 0, W, 32'h40, 0, 32'h5555AAAA, 0); ex(1, 0, 4'hF, 32'h40, 0, 0, 1, 0); tick;
        set(1, 0, W, 32'h40, 0, 32'h5555AAAA, 1); ex(1, 0, 4'hF, 32'h40, 0, 0, 0, 32'h5555AAAA); tick;
        // timeout in beat 1 of split store; retry starts again at beat 0
        set(1, 1, W, 32'h42, 32'h11223344, 0, 1); ex(1, 1, 4'hC, 32'h40, 32'h33440000, 1, 0, 0); tick;
        for (int i = 0; i < 3; i++) begin
            set(1, 1, W, 32'h42, 32'h11223344, 0, 0); ex(1, 1, 4'h3, 32'h44, 32'h00001122, 1, 0, 0); tick;
        end
        set(1, 1, W, 32'h42, 32'h11223344, 0, 0); ex(1, 1, 4'h3, 32'h44, 32'h00001122, 0, 1, 0); tick;
        set(1, 1, W, 32'h42, 32'h11223344, 0, 1); ex(1, 1, 4'hC, 32'h40, 32'h33440000, 1, 0, 0); tick;
        set(1, 1, W, 32'h42, 32'h11223344, 0, 1); ex(1, 1, 4'h3, 32'h44, 32'h00001122, 0, 0, 0); tick;
        // dropped request abandons the split
        set(1, 0, W, 32'h1002, 0, 32'hDDCCBBAA, 1); ex(1, 0, 4'hC, 32'h1000, 0, 1, 0, 0); tick;
        set(0, 0, B, 0, 0, 0, 0); tick;
        set(1, 0, W, 32'h1002, 0, 32'h87654321, 1); ex(1, 0, 4'hC, 32'h1000, 0, 1, 0, 0); tick;
        set(1, 0, W, 32'h1002, 0, 32'h0FEDCBA9, 1); ex(1, 0, 4'h3, 32'h1004, 0, 0, 0, 32'hCBA98765); tick;
        // illegal size
        set(1, 0, 3'b111, 0, 0, 0, 1); ex(0, 0, 4'h0, 0, 0, 0, 1, 0); tick;
        // reset mid-split
        set(1, 0, W, 32'h1002, 0, 32'hDDCCBBAA, 1); ex(1, 0, 4'hC, 32'h1000, 0, 1, 0, 0); tick;
        rst_ni = 1'b0;
        set(1, 0, W, 32'h1002, 0, 32'hDDCCBBAA, 0); ex(1, 0, 4'hC, 32'h1000, 0, 1, 0, 0); tick;
        rst_ni = 1'b1;
        set(1, 0, W, 32'h1002, 0, 32'h87654321, 1); ex(1, 0, 4'hC, 32'h1000, 0, 1, 0, 0); tick;
        set(1, 0, W, 32'h1002, 0, 32'h0FEDCBA9, 1); ex(1, 0, 4'h3, 32'h1004, 0, 0, 0, 32'hCBA98765); tick;
        // misalignment disabled
        set2(1, 0, H, 32'h3, 0, 0, 1); ex2(0, 0, 4'h0, 0, 0, 0, 1, 0); tick;
        set2(1, 0, 3'b011, 0, 0, 0, 1); ex2(0, 0, 4'h0, 0, 0, 0, 1, 0); tick;
        set2(1, 0, W, 32'h8, 0, 32'h13579BDF, 1); ex2(1, 0, 4'hF, 32'h8, 0, 0, 0, 32'h13579BDF); tick;
        set2(1, 0, H, 32'h2, 0, 32'h80001234, 1); ex2(1, 0, 4'hC, 0, 0, 0, 0, 32'hFFFF8000); tick;
        set(0, 0, B, 0, 0, 0, 0); tick;
        done = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/riscv_lsu_split.md
RISCV_LSU_SPLIT -- requirements
Module: riscv_lsu_split

Interface
REQ-001 Clocking SHALL be a single clock clk_i; reset rst_ni SHALL be asynchronous and active-low.
REQ-002 Parameter TIMEOUT_CYCLES, default 16: memory-wait cycles allowed per beat before abort; 0 disables the timeout.
REQ-003 Parameter MISALIGN_EN, default 1: 1 splits misaligned accesses into two beats; 0 reports them as errors.
REQ-004 Ports SHALL be:
- clk_i in 1: clock
- rst_ni in 1: async active-low reset
- core_req_i in 1: access request, held stable while stalled
- core_we_i in 1: 1 = store
- core_size_i in 3: LDST_B/H/W/BU/HU encodings from riscv_pkg
- core_addr_i in 32: byte address
- core_wd_i in 32: store data, LSB-aligned
- core_rd_o out 32: load result
- core_stall_o out 1: access not yet complete
- core_err_o out 1: one-cycle access-fault pulse
- mem_req_o out 1: memory request
- mem_we_o out 1: memory write enable
- mem_be_o out 4: byte enables
- mem_addr_o out 32: word-aligned address
- mem_wd_o out 32: write data
- mem_rd_i in 32: read data, valid with mem_ready_i
- mem_ready_i in 1: beat accepted/completed

Function
REQ-005 off = core_addr_i[1:0]; nbytes = 1 (B/BU), 2 (H/HU), 4 (W); stores SHALL treat BU/HU as B/H.
REQ-006 An access SHALL be split when off+nbytes > 4; otherwise it is aligned (one beat).
REQ-007 Sizes outside the five encodings, or split accesses with MISALIGN_EN=0, SHALL be illegal: mem_req_o=0, core_stall_o=0, core_err_o=1 in the same cycle.
REQ-008 State SHALL be: beat_q (0/1), lo_q[31:0] (captured beat-0 read data), cnt_q (timeout counter).
REQ-009 mem_req_o = core_req_i && access legal; mem_we_o = core_we_i; all memory outputs SHALL be combinational and stable while mem_ready_i=0.
REQ-010 mem_addr_o = {core_addr_i[31:2],2'b00} + 4*beat_q.
REQ-011 be8 = ((1<<nbytes)-1) << off; wd64 = core_wd_i << (8*off); mem_be_o / mem_wd_o = low halves for beat 0, high halves for beat 1; disabled lanes SHALL be zero.
REQ-012 fin = last beat && mem_ready_i; core_stall_o = core_req_i && legal && !fin && !timeout.
REQ-013 When split beat 0 completes (mem_ready_i=1, beat_q=0): lo_q <= mem_rd_i, beat_q <= 1, cnt_q <= 0; core_stall_o stays 1.
REQ-014 On fin: beat_q <= 0, cnt_q <= 0; core_rd_o is valid that cycle (zero latency after the final ready).
REQ-015 Load result: r64 = split ? {mem_rd_i, lo_q} : {32'b0, mem_rd_i}; field = r64 >> (8*off), truncated to nbytes; B/H SHALL sign-extend, BU/HU SHALL zero-extend; W is passed through.
REQ-016 core_rd_o SHALL be 0 when there is no load, on an error, or on an illegal access.
REQ-017 cnt_q SHALL increment each cycle with mem_req_o=1 and mem_ready_i=0.
REQ-018 Timeout fires when TIMEOUT_CYCLES>0 && cnt_q == TIMEOUT_CYCLES-1 && mem_ready_i=0; that cycle: core_err_o=1, core_stall_o=0, beat_q and cnt_q <= 0.
REQ-019 A timeout in beat 1 of a split store SHALL leave beat 0's write committed; no rollback.
REQ-020 If core_req_i=0, beat_q and cnt_q SHALL clear at the next edge, so a deasserted request abandons the access.
REQ-021 A request in the cycle after fin SHALL be treated as a new access starting at beat 0.

Reset
REQ-022 rst_ni=0 SHALL immediately clear beat_q, lo_q and cnt_q, including mid-split.
REQ-023 Outputs SHALL then follow REQ-009..REQ-018 from cleared state; with core_req_i=0, all outputs are 0.

Verification
REQ-024 LW addr 0x1002, beat 0 mem_rd 0xDDCCBBAA with ready, beat 1 0x44332211 with ready -> mem_addr 0x1000 then 0x1004, be 1100 then 0011, stall 1,0, core_rd_o 0x2211DDCC.
REQ-025 SW addr 0x0103, wd 0xA1B2C3D4 -> beat 0: addr 0x100, be 1000, wd 0xD4000000; beat 1: addr 0x104, be 0111, wd 0x00A1B2C3.
REQ-026 Aligned loads with ready=1 -> no stall after ready: LB addr 0x3, mem_rd 0x80000000 -> 0xFFFFFF80; LHU addr 0x2, mem_rd 0xBEEF1234 -> 0x0000BEEF.
REQ-027 TIMEOUT_CYCLES=4, LW aligned, ready held 0 -> stall=1 for 3 cycles, 4th cycle stall=0, err=1, core_rd_o=0; next request restarts at beat 0.
REQ-028 MISALIGN_EN=0, LH addr 0x3 -> mem_req_o=0, err=1, stall=0 same cycle; size 3'b011 -> same response.
REQ-029 rst_ni low after beat 0 of a split load -> beat_q=0 asynchronously; after release, a held request reissues beat 0 at the base address.
